booth_mul_seq: RTL
==================

Name: booth_mul_seq

Overview:
- Sequential radix-2 Booth multiplier: signed 16x16 -> signed 32-bit product, one multiplier bit per cycle.
- Sits directly upstream of the existing 32-bit add_sub datapath.
- Instantiates add_sub as its only adder; drives add_sub operands and select each cycle and consumes its 32-bit sum as the next partial product.
- valid/ready handshake on both input and output.

Parameters:
- MUL_W, 16, operand width. Only 16 is legal, because add_sub is fixed at 32 bits; elaboration fails on any other value.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  16  multiplicand, two's complement
- in_b  in  16  multiplier, two's complement
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_prod  out  32  signed product a*b
- busy  out  1  high in RUN or DONE

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_prod=0, busy=0, internal acc/mcand/mplier/cnt=0.
- rst_n low at any clock edge, including mid-RUN, aborts the operation with no output. The first edge after release behaves as IDLE.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready: capture mcand = sign-extended in_a (32b), mplier = in_b, prev bit q(-1)=0, acc=0, cnt=0; go to RUN.
  - RUN: in_ready=0. Each cycle, iteration i=cnt examines pair (mplier[i], q(i-1)):
    - 00 or 11: add_sub b=0, sub=0.
    - 01: b=mcand<<i, sub=0.
    - 10: b=mcand<<i, sub=1.
    - add_sub a=acc. At the edge, acc <= add_sub.sum and cnt <= cnt+1.
  - After iteration 15 (cnt==15 at the edge): out_prod <= final sum, out_valid <= 1, go to DONE.
  - DONE: out_valid and out_prod held stable until out_ready. On out_valid&&out_ready: out_valid <= 0, go to IDLE. No accept in the same cycle; in_ready is asserted the following cycle.
- Latency: accept edge E0; product valid from edge E16 (16 cycles). Minimum initiation interval is 18 cycles with out_ready tied high.
- Arithmetic:
  - Shifts are modulo 2^32.
  - Wrap inside add_sub is intended; the final product is exact for every signed 16-bit pair, including -32768*-32768 = 0x40000000.
- in_a/in_b are ignored outside the IDLE accept cycle. in_valid may drop without penalty while in_ready=0.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro BOOTH_SKIP_EN.
- Defined: early termination. After processing iteration i, if mplier[15:i] are all equal (all remaining pairs are 00/11), result is final: out_prod <= sum, go to DONE at that edge.
  - Latency is 1..16 cycles. b=0 finishes at E1; b=1 finishes at E2.
- Undefined: fixed 16-cycle latency; no skip comparator is synthesized.

Decomposition:
- Package mul_pkg:
  - constants MUL_W=16, PROD_W=32, CNT_W=4;
  - typedef enum logic[1:0] state_t {IDLE, RUN, DONE};
  - typedef enum for Booth op {OP_NOP, OP_ADD, OP_SUB}.
- Sub-modules:
  - existing add_sub (32b) is the only child;
  - Booth pair recode is a small combinational function in mul_pkg, not a separate module.

Test Plan:
1. a=3, b=5, out_ready=1 -> out_prod=0x0000000F, out_valid rises exactly 16 cycles after accept (macro off).
2. a=-3 (0xFFFD), b=5 -> 0xFFFFFFF1. a=0x7FFF, b=0x8000 -> 0xC0008000. a=0x8000, b=0x8000 -> 0x40000000.
3. Backpressure: a=7, b=9, out_ready low 10 cycles after out_valid -> out_prod=0x3F held stable, in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
4. Reset mid-op: accept a=100, b=200, drop rst_n at cycle 8 -> next cycle out_valid=0, in_ready=1; next op a=2, b=-2 gives 0xFFFFFFFC.
5. BOOTH_SKIP_EN defined:
   - a=1, b=1 -> out_prod=1 valid at E2.
   - a=5, b=0 -> 0 at E1.
   - a=5, b=-1 (0xFFFF) -> 0xFFFFFFFB at E1.
6. Random 2000 signed pairs with random out_ready stalls -> out_prod == a*b every transaction; no out_valid without a prior accept.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants, FSM/Booth-op types and the radix-2 Booth pair recoder
// for the sequential multiplier.
package mul_pkg;

    localparam int unsigned MUL_W  = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_t;

    // Pair (q(i), q(i-1)): 01 adds the shifted multiplicand, 10 subtracts it.
    function automatic booth_op_t booth_recode(input logic bit_cur, input logic bit_prev);
        booth_op_t op;
        case ({bit_cur, bit_prev})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/add_sub.sv
// 32-bit adder/subtractor: sum = sub ? a - b : a + b, wrapping modulo 2^32.
module add_sub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum
);

    always_comb begin
        sum = sub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed 16x16 -> 32, one multiplier bit per cycle.
// Optional early termination when BOOTH_SKIP_EN is defined.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned MUL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MUL_W-1:0]   in_a,
    input  logic [MUL_W-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PROD_W-1:0]  out_prod,
    output logic               busy
);

    // The downstream adder is fixed at 32 bits, so only a 16-bit operand fits.
    if (MUL_W != 16) begin : g_bad_width
        $error("booth_mul_seq: MUL_W must be 16");
    end

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MUL_W - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_t              state_q;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   mcand_q;
    logic [MUL_W-1:0]    mplier_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                q_prev;
    booth_op_t           op;
    logic [PROD_W-1:0]   mcand_shift;
    logic [PROD_W-1:0]   add_b;
    logic                add_sel;
    logic [PROD_W-1:0]   sum;
    logic                last_iter;

    always_comb begin
        q_prev      = (cnt_q == '0) ? 1'b0 : mplier_q[cnt_q - CntOne];
        op          = booth_recode(mplier_q[cnt_q], q_prev);
        mcand_shift = mcand_q << cnt_q;
        add_b       = '0;
        add_sel     = 1'b0;
        case (op)
            OP_ADD: add_b = mcand_shift;
            OP_SUB: begin
                add_b   = mcand_shift;
                add_sel = 1'b1;
            end
            default: ;
        endcase
    end

    add_sub u_add_sub (
        .a   (acc_q),
        .b   (add_b),
        .sub (add_sel),
        .sum (sum)
    );

`ifdef BOOTH_SKIP_EN
    // mplier[15:i] all equal <=> its arithmetic shift by i is all zeros or all ones.
    logic signed [MUL_W-1:0] mplier_rest;
    assign mplier_rest = $signed(mplier_q) >>> cnt_q;
    assign last_iter   = (cnt_q == CntLast) || (mplier_rest == '0) || (&mplier_rest);
`else
    assign last_iter = (cnt_q == CntLast);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_prod  <= '0;
            busy      <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q  <= {{(PROD_W - MUL_W){in_a[MUL_W-1]}}, in_a};
                        mplier_q <= in_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= sum;
                    cnt_q <= cnt_q + CntOne;
                    if (last_iter) begin
                        out_prod  <= sum;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // Accept reopens only on the cycle after the product leaves.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
